// File: rtl/fifo_replay_ctrl_if.sv
// Handshake bundle between the replay sequencer and its host, load stream, consumer and buffer.
// master = sequencer side, slave = environment side.
interface fifo_replay_ctrl_if #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_SIZE  = 4608,
    parameter int PASS_W     = 8,
    parameter int HOLD_W     = 4
);
    localparam int LEN_W = $clog2(FIFO_SIZE + 1);

    logic                  start;
    logic [LEN_W-1:0]      cfg_len;
    logic [PASS_W-1:0]     cfg_passes;
    logic [HOLD_W-1:0]     cfg_hold;
    logic                  ld_valid;
    logic                  ld_ready;
    logic [DATA_WIDTH-1:0] ld_data;
    logic                  out_ready;
    logic                  wr_clr;
    logic                  wr_en;
    logic                  wr_inc;
    logic [DATA_WIDTH-1:0] data_in_fifo;
    logic                  rd_clr;
    logic                  rd_en;
    logic                  rd_inc;
    logic                  out_valid;
    logic                  out_last;
    logic [PASS_W-1:0]     pass_idx;
    logic                  busy;
    logic                  done;
    logic                  cfg_err;

    modport master (
        input  start, cfg_len, cfg_passes, cfg_hold, ld_valid, ld_data, out_ready,
        output ld_ready, wr_clr, wr_en, wr_inc, data_in_fifo, rd_clr, rd_en, rd_inc,
               out_valid, out_last, pass_idx, busy, done, cfg_err
    );

    modport slave (
        output start, cfg_len, cfg_passes, cfg_hold, ld_valid, ld_data, out_ready,
        input  ld_ready, wr_clr, wr_en, wr_inc, data_in_fifo, rd_clr, rd_en, rd_inc,
               out_valid, out_last, pass_idx, busy, done, cfg_err
    );
endinterface

// File: rtl/fifo_replay_ctrl.sv
// Load/replay sequencer for one FIFO buffer: fills it from a valid/ready stream, then replays
// the contents cfg_passes times with optional per-word hold, realigning the 1-cycle read latency.
module fifo_replay_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_SIZE  = 4608,
    parameter int PASS_W     = 8,
    parameter int HOLD_W     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    fifo_replay_ctrl_if.master bus
);
    localparam int LEN_W = $clog2(FIFO_SIZE + 1);

    typedef enum logic [2:0] {S_IDLE, S_CLR, S_LOAD, S_READ, S_RCLR, S_FIN} state_t;

    state_t            state_q;
    logic [LEN_W-1:0]  len_q, cnt_q;
    logic [PASS_W-1:0] passes_q, pass_q;
    logic [HOLD_W-1:0] hold_q, hcnt_q;
    logic              wclr_q, rclr_q, busy_q, done_q, err_q, ovld_q, olast_q;

    logic ld_fire, rd_en, rd_inc, word_last, pass_last, eop, cfg_bad;

    assign ld_fire   = (state_q == S_LOAD) && bus.ld_valid;
    assign rd_en     = (state_q == S_READ) && bus.out_ready;
    assign rd_inc    = rd_en && (hcnt_q == hold_q);
    // cnt_q serves as the load counter in LOAD and the word counter in READ
    assign word_last = (cnt_q == len_q - LEN_W'(1));
    assign pass_last = (pass_q == passes_q - PASS_W'(1));
    assign eop       = rd_inc && word_last;
    assign cfg_bad   = (bus.cfg_len == '0) || (bus.cfg_len > LEN_W'(FIFO_SIZE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            len_q    <= '0;
            cnt_q    <= '0;
            passes_q <= '0;
            pass_q   <= '0;
            hold_q   <= '0;
            hcnt_q   <= '0;
            wclr_q   <= 1'b0;
            rclr_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            ovld_q   <= 1'b0;
            olast_q  <= 1'b0;
        end else begin
            wclr_q  <= 1'b0;
            rclr_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            // buffer data appears one cycle after rd_en, so status follows it by one
            ovld_q  <= rd_en;
            olast_q <= eop;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        if (cfg_bad) begin
                            err_q <= 1'b1;
                        end else begin
                            len_q    <= bus.cfg_len;
                            passes_q <= bus.cfg_passes;
                            hold_q   <= bus.cfg_hold;
                            pass_q   <= '0;
                            cnt_q    <= '0;
                            hcnt_q   <= '0;
                            wclr_q   <= 1'b1;
                            rclr_q   <= 1'b1;
                            busy_q   <= 1'b1;
                            state_q  <= S_CLR;
                        end
                    end
                end
                S_CLR: state_q <= S_LOAD;
                S_LOAD: begin
                    if (ld_fire) begin
                        if (word_last) begin
                            cnt_q <= '0;
                            if (passes_q == '0) begin
                                done_q  <= 1'b1;
                                state_q <= S_FIN;
                            end else begin
                                state_q <= S_READ;
                            end
                        end else begin
                            cnt_q <= cnt_q + LEN_W'(1);
                        end
                    end
                end
                S_READ: begin
                    if (rd_en) begin
                        if (rd_inc) begin
                            hcnt_q <= '0;
                            if (word_last) begin
                                cnt_q <= '0;
                                if (pass_last) begin
                                    done_q  <= 1'b1;
                                    state_q <= S_FIN;
                                end else begin
                                    rclr_q  <= 1'b1;
                                    state_q <= S_RCLR;
                                end
                            end else begin
                                cnt_q <= cnt_q + LEN_W'(1);
                            end
                        end else begin
                            hcnt_q <= hcnt_q + HOLD_W'(1);
                        end
                    end
                end
                S_RCLR: begin
                    pass_q  <= pass_q + PASS_W'(1);
                    cnt_q   <= '0;
                    hcnt_q  <= '0;
                    state_q <= S_READ;
                end
                S_FIN: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.ld_ready     = (state_q == S_LOAD);
    assign bus.wr_en        = ld_fire;
    assign bus.wr_inc       = (state_q == S_LOAD);
    assign bus.wr_clr       = wclr_q;
    assign bus.data_in_fifo = bus.ld_data;
    assign bus.rd_clr       = rclr_q;
    assign bus.rd_en        = rd_en;
    assign bus.rd_inc       = rd_inc;
    assign bus.out_valid    = ovld_q;
    assign bus.out_last     = olast_q;
    assign bus.pass_idx     = pass_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.cfg_err      = err_q;
endmodule

// File: tb/tb_fifo_replay_ctrl.sv
// Directed bench for fifo_replay_ctrl: table of jobs plus hand sequences, with a behavioural buffer.
module tb_fifo_replay_ctrl;
    localparam int DATA_WIDTH = 16;
    localparam int FIFO_SIZE  = 4608;
    localparam int PASS_W     = 8;
    localparam int HOLD_W     = 4;
    localparam int LEN_W      = $clog2(FIFO_SIZE + 1);

    logic clk, rst_n;

    fifo_replay_ctrl_if #(.DATA_WIDTH(DATA_WIDTH), .FIFO_SIZE(FIFO_SIZE),
                          .PASS_W(PASS_W), .HOLD_W(HOLD_W)) bus ();

    fifo_replay_ctrl #(.DATA_WIDTH(DATA_WIDTH), .FIFO_SIZE(FIFO_SIZE),
                       .PASS_W(PASS_W), .HOLD_W(HOLD_W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Buffer model: contents survive reset, pointers only move on clr/inc, 1-cycle read latency.
    logic [DATA_WIDTH-1:0] mem [0:FIFO_SIZE-1];
    logic [DATA_WIDTH-1:0] dout;
    int                    wp, rp;
    initial begin
        wp   = 0;
        rp   = 0;
        dout = '0;
    end
    always @(posedge clk) begin
        if (bus.wr_clr) wp <= 0;
        else if (bus.wr_en && bus.wr_inc && wp < FIFO_SIZE) begin
            mem[wp] <= bus.data_in_fifo;
            wp      <= wp + 1;
        end
        if (bus.rd_clr) rp <= 0;
        else if (bus.rd_en && bus.rd_inc) rp <= rp + 1;
        dout <= (bus.rd_en && rp < FIFO_SIZE) ? mem[rp] : '0;
    end

    typedef struct {
        int len; int passes; int hold;
        int gap_at; int gap_len; int poke_at; bit rnd; int base;
        int exp_reads; int exp_gaps;
    } vec_t;

    typedef struct { logic [DATA_WIDTH-1:0] d; bit last; int pass; } exp_t;

    exp_t exp_q[$];
    bit   rdinc_log[$];
    int   n_cmp, n_err;
    int   vld_cnt, gaps, done_cnt, clr_cnt, rclr_cnt, err_cnt, wr_cnt;
    bit   seen, done_seen, fin_vld_exp, s_acc;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] outs();
        return 32'({bus.ld_ready, bus.wr_clr, bus.wr_en, bus.wr_inc, bus.rd_clr, bus.rd_en,
                    bus.rd_inc, bus.out_valid, bus.out_last, bus.busy, bus.done, bus.cfg_err,
                    bus.pass_idx});
    endfunction

    // One clock: sample at negedge, then return at posedge+1 ready to drive.
    task automatic step();
        exp_t e;
        @(negedge clk);
        s_acc = bus.ld_valid && bus.ld_ready;
        chk("excl", 32'((bus.wr_en && bus.rd_en) ||
                        ((bus.wr_clr || bus.rd_clr) && (bus.wr_en || bus.rd_en))), 0);
        if (bus.rd_en) rdinc_log.push_back(bus.rd_inc);
        if (bus.wr_en && bus.wr_inc) wr_cnt++;
        if (bus.wr_clr) clr_cnt++;
        if (bus.rd_clr && !bus.wr_clr) rclr_cnt++;
        if (bus.cfg_err) err_cnt++;
        if (bus.out_valid) begin
            vld_cnt++;
            seen = 1;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL extra_read: out_valid with data %0h but nothing expected", dout);
            end else begin
                e = exp_q.pop_front();
                chk("data", dout, e.d);
                chk("last", bus.out_last, e.last);
                chk("pass", bus.pass_idx, e.pass);
            end
        end else if (seen && !done_seen) begin
            gaps++;
        end
        if (bus.done) begin
            done_cnt++;
            done_seen = 1;
            chk("fin_valid", bus.out_valid, fin_vld_exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic build_exp(input vec_t v);
        exp_q.delete();
        seen        = 0;
        done_seen   = 0;
        vld_cnt     = 0;
        gaps        = 0;
        fin_vld_exp = (v.passes != 0);
        for (int p = 0; p < v.passes; p++)
            for (int w = 0; w < v.len; w++)
                for (int h = 0; h <= v.hold; h++)
                    exp_q.push_back('{d: DATA_WIDTH'(v.base + w),
                                      last: (w == v.len - 1) && (h == v.hold), pass: p});
    endtask

    task automatic start_load(input vec_t v);
        int i, n;
        bus.cfg_len    = LEN_W'(v.len);
        bus.cfg_passes = PASS_W'(v.passes);
        bus.cfg_hold   = HOLD_W'(v.hold);
        bus.out_ready  = 1'b1;
        bus.start      = 1'b1;
        step();
        bus.start = 1'b0;
        i = 0;
        n = 0;
        while (i < v.len && n < v.len * 8 + 20) begin
            bus.ld_valid = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.ld_data  = DATA_WIDTH'(v.base + i);
            step();
            if (s_acc) i++;
            n++;
        end
        bus.ld_valid = 1'b0;
        chk("load_words", i, v.len);
    endtask

    task automatic run_job(input vec_t v);
        int d0, c0, r0, e0, w0, k, budget;
        build_exp(v);
        d0 = done_cnt; c0 = clr_cnt; r0 = rclr_cnt; e0 = err_cnt; w0 = wr_cnt;
        start_load(v);
        k      = 0;
        budget = v.exp_reads + v.passes + v.gap_len + 10;
        while (!done_seen && k < budget) begin
            bus.out_ready = !(k >= v.gap_at && k < v.gap_at + v.gap_len);
            bus.start     = (k == v.poke_at);
            if (k == v.poke_at) begin
                bus.cfg_len    = LEN_W'(2);
                bus.cfg_passes = PASS_W'(3);
            end
            step();
            k++;
        end
        bus.start     = 1'b0;
        bus.out_ready = 1'b1;
        chk("done_seen", done_seen, 1);
        chk("busy_idle", bus.busy, 0);
        chk("exp_left", exp_q.size(), 0);
        chk("reads", vld_cnt, v.exp_reads);
        chk("gaps", gaps, v.exp_gaps);
        chk("done_cnt", done_cnt - d0, 1);
        chk("wr_clr_cnt", clr_cnt - c0, 1);
        chk("rd_clr_cnt", rclr_cnt - r0, (v.passes > 0) ? v.passes - 1 : 0);
        chk("cfg_err_cnt", err_cnt - e0, 0);
        chk("writes", wr_cnt - w0, v.len);
    endtask

    vec_t vecs[8];

    initial begin
        int   e0, c0, n;
        vec_t v;
        vecs[0] = '{len:4,    passes:2, hold:0, gap_at:-1, gap_len:0, poke_at:-1, rnd:0, base:'h0A,   exp_reads:8,    exp_gaps:1};
        vecs[1] = '{len:3,    passes:1, hold:1, gap_at:-1, gap_len:0, poke_at:-1, rnd:0, base:'h5A0,  exp_reads:6,    exp_gaps:0};
        vecs[2] = '{len:4,    passes:1, hold:0, gap_at:2,  gap_len:3, poke_at:-1, rnd:0, base:'h700,  exp_reads:4,    exp_gaps:3};
        vecs[3] = '{len:5,    passes:0, hold:0, gap_at:-1, gap_len:0, poke_at:-1, rnd:0, base:'h800,  exp_reads:0,    exp_gaps:0};
        vecs[4] = '{len:2,    passes:3, hold:2, gap_at:4,  gap_len:2, poke_at:-1, rnd:1, base:'h900,  exp_reads:18,   exp_gaps:4};
        vecs[5] = '{len:1,    passes:2, hold:0, gap_at:-1, gap_len:0, poke_at:-1, rnd:0, base:'hB00,  exp_reads:2,    exp_gaps:1};
        vecs[6] = '{len:4608, passes:1, hold:0, gap_at:-1, gap_len:0, poke_at:-1, rnd:1, base:'h1000, exp_reads:4608, exp_gaps:0};
        vecs[7] = '{len:4,    passes:1, hold:0, gap_at:-1, gap_len:0, poke_at:1,  rnd:0, base:'hC00,  exp_reads:4,    exp_gaps:0};

        n_cmp = 0; n_err = 0;
        vld_cnt = 0; gaps = 0; done_cnt = 0; clr_cnt = 0; rclr_cnt = 0; err_cnt = 0; wr_cnt = 0;
        seen = 0; done_seen = 0; fin_vld_exp = 0; s_acc = 0;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.cfg_len = '0; bus.cfg_passes = '0; bus.cfg_hold = '0;
        bus.ld_valid = 1'b0; bus.ld_data = '0; bus.out_ready = 1'b1;
        #12;
        chk("rst_state", outs(), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 8; i++) run_job(vecs[i]);

        // rd_inc must alternate 0,1 when each word is held for two reads
        rdinc_log.delete();
        run_job(vecs[1]);
        chk("rdinc_len", rdinc_log.size(), 6);
        for (int i = 0; i < 6 && i < rdinc_log.size(); i++) chk("rdinc_pat", rdinc_log[i], i % 2);

        // illegal lengths: one cfg_err pulse each, no clear, stays idle
        for (int j = 0; j < 2; j++) begin
            e0 = err_cnt; c0 = clr_cnt;
            bus.cfg_len    = (j == 0) ? LEN_W'(0) : LEN_W'(FIFO_SIZE + 1);
            bus.cfg_passes = PASS_W'(1);
            bus.start      = 1'b1;
            step();
            bus.start = 1'b0;
            step();
            chk("cfg_err_busy", bus.busy, 0);
            step();
            chk("cfg_err_pulse", err_cnt - e0, 1);
            chk("cfg_err_noclr", clr_cnt - c0, 0);
        end

        // async reset in the middle of pass 1, then a fresh job
        v = '{len:4, passes:2, hold:0, gap_at:-1, gap_len:0, poke_at:-1, rnd:0, base:'hD00, exp_reads:8, exp_gaps:1};
        build_exp(v);
        start_load(v);
        n = 0;
        while (n < 20) begin
            step();
            n++;
            if (bus.pass_idx == 1 && bus.out_valid) break;
        end
        chk("reach_pass1", bus.pass_idx, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst", outs(), 0);
        step();
        step();
        rst_n = 1'b1;
        exp_q.delete();
        v = '{len:2, passes:1, hold:0, gap_at:-1, gap_len:0, poke_at:-1, rnd:0, base:'hE00, exp_reads:2, exp_gaps:0};
        run_job(v);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
